fp4mac_axil_master: RTL and testbench

- AXI-Lite initiator that drives the FP4 MAC register map (0x00 control, 0x04 A, 0x08 B, 0x0C result with valid in bit 31) from a simple command/response stream.
- Sits between a local sequencer (or test harness) and the MAC's AXI-Lite slave port.
- Converts each command into an ordered series of single-beat AXI-Lite writes and result-polling reads.

---
 rtl/fp4mac_axil_master.sv | 182 ++++++++++++++++++
 tb/tb_fp4mac_axil_master.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp4mac_axil_master.sv
// AXI-Lite initiator turning FP4 MAC commands into register writes plus result polling.
// Command accepted only in IDLE; each beat waits on its slave handshake; response held until consumed.
module fp4mac_axil_master #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int          POLL_MAX  = 16
) (
  input  logic        m_axi_aclk,
  input  logic        m_axi_aresetn,
  input  logic        i_cmd_valid,
  output logic        o_cmd_ready,
  input  logic [3:0]  i_cmd_a,
  input  logic [3:0]  i_cmd_b,
  input  logic        i_cmd_clr,
  input  logic        i_cmd_read,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [3:0]  o_rsp_data,
  output logic        o_rsp_err,
  output logic [31:0] m_axi_awaddr,
  output logic        m_axi_awvalid,
  input  logic        m_axi_awready,
  output logic [31:0] m_axi_wdata,
  output logic [3:0]  m_axi_wstrb,
  output logic        m_axi_wvalid,
  input  logic        m_axi_wready,
  input  logic [1:0]  m_axi_bresp,
  input  logic        m_axi_bvalid,
  output logic        m_axi_bready,
  output logic [31:0] m_axi_araddr,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  input  logic [31:0] m_axi_rdata,
  input  logic [1:0]  m_axi_rresp,
  input  logic        m_axi_rvalid,
  output logic        m_axi_rready
);

  localparam logic [7:0] PMAX = 8'(POLL_MAX);

  typedef enum logic [2:0] {IDLE, WR, WR_RESP, RD_ADDR, RD_DATA, RSP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  a_q, b_q;
  logic        read_q;
  logic [2:0]  step;
  logic        aw_done, w_done;
  logic [7:0]  poll_cnt;
  logic [3:0]  rsp_data_q;
  logic        rsp_err_q;
  logic [31:0] wr_off, wr_dat;

  logic cmd_hs, aw_hs, w_hs, b_hs, r_hs, wr_both, last_step, poll_last, rd_stop;
  logic unused_rdata;

  assign cmd_hs    = i_cmd_valid && o_cmd_ready;
  assign aw_hs     = m_axi_awvalid && m_axi_awready;
  assign w_hs      = m_axi_wvalid && m_axi_wready;
  assign b_hs      = m_axi_bvalid && m_axi_bready;
  assign r_hs      = m_axi_rvalid && m_axi_rready;
  assign wr_both   = (aw_done || aw_hs) && (w_done || w_hs);
  assign last_step = (step == 3'd5);
  assign poll_last = ((poll_cnt + 8'd1) == PMAX);
  assign rd_stop   = (m_axi_rresp != 2'b00) || m_axi_rdata[31] || poll_last;

  assign m_axi_wstrb  = 4'hF;
  assign o_rsp_data   = rsp_data_q;
  assign o_rsp_err    = rsp_err_q;
  assign unused_rdata = ^m_axi_rdata[30:4];

  // Write list: steps 0/1 pulse the accumulator clear, 2/3 load operands, 4/5 pulse start.
  always_comb begin
    wr_off = 32'h0;
    wr_dat = 32'h0;
    case (step)
      3'd0:    wr_dat = 32'h2;
      3'd2:    begin wr_off = 32'h4; wr_dat = {28'b0, a_q}; end
      3'd3:    begin wr_off = 32'h8; wr_dat = {28'b0, b_q}; end
      3'd4:    wr_dat = 32'h1;
      default: wr_dat = 32'h0;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_cmd_valid) state_nxt = WR;
      WR:      if (wr_both) state_nxt = WR_RESP;
      WR_RESP: if (m_axi_bvalid) begin
                 if (m_axi_bresp != 2'b00) state_nxt = RSP;
                 else if (!last_step)      state_nxt = WR;
                 else                      state_nxt = read_q ? RD_ADDR : RSP;
               end
      RD_ADDR: if (m_axi_arready) state_nxt = RD_DATA;
      RD_DATA: if (m_axi_rvalid) state_nxt = rd_stop ? RSP : RD_ADDR;
      RSP:     if (i_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_cmd_ready   = 1'b0;
    o_rsp_valid   = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_awaddr  = 32'h0;
    m_axi_wvalid  = 1'b0;
    m_axi_wdata   = 32'h0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_araddr  = 32'h0;
    m_axi_rready  = 1'b0;
    case (state)
      IDLE:    o_cmd_ready = 1'b1;
      WR:      begin
                 m_axi_awvalid = !aw_done;
                 m_axi_wvalid  = !w_done;
                 m_axi_awaddr  = ADDR_BASE + wr_off;
                 m_axi_wdata   = wr_dat;
               end
      WR_RESP: m_axi_bready = 1'b1;
      RD_ADDR: begin
                 m_axi_arvalid = 1'b1;
                 m_axi_araddr  = ADDR_BASE + 32'h0C;
               end
      RD_DATA: m_axi_rready = 1'b1;
      RSP:     o_rsp_valid = 1'b1;
      default: o_cmd_ready = 1'b0;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      a_q        <= 4'h0;
      b_q        <= 4'h0;
      read_q     <= 1'b0;
      step       <= 3'd0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      poll_cnt   <= 8'd0;
      rsp_data_q <= 4'h0;
      rsp_err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cmd_hs) begin
                a_q        <= i_cmd_a;
                b_q        <= i_cmd_b;
                read_q     <= i_cmd_read;
                step       <= i_cmd_clr ? 3'd0 : 3'd2;
                aw_done    <= 1'b0;
                w_done     <= 1'b0;
                poll_cnt   <= 8'd0;
                rsp_data_q <= 4'h0;
                rsp_err_q  <= 1'b0;
              end
        WR: if (wr_both) begin
              aw_done <= 1'b0;
              w_done  <= 1'b0;
            end else begin
              if (aw_hs) aw_done <= 1'b1;
              if (w_hs)  w_done  <= 1'b1;
            end
        WR_RESP: if (b_hs) begin
                   if (m_axi_bresp != 2'b00) rsp_err_q <= 1'b1;
                   else if (!last_step)      step <= step + 3'd1;
                 end
        RD_DATA: if (r_hs) begin
                   rsp_data_q <= m_axi_rdata[3:0];
                   poll_cnt   <= poll_cnt + 8'd1;
                   // A set valid bit wins over the poll limit on the final read.
                   if ((m_axi_rresp != 2'b00) || (!m_axi_rdata[31] && poll_last))
                     rsp_err_q <= 1'b1;
                 end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fp4mac_axil_master.sv
// Directed bench for fp4mac_axil_master with a configurable AXI-Lite slave model.
module tb_fp4mac_axil_master;

  localparam logic [31:0] BASE = 32'h0001_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_clr, cmd_read;
  logic [3:0]  cmd_a, cmd_b;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [3:0]  rsp_data;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  always #5 clk = ~clk;

  fp4mac_axil_master #(.ADDR_BASE(BASE), .POLL_MAX(4)) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_cmd_clr(cmd_clr), .i_cmd_read(cmd_read),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_data(rsp_data), .o_rsp_err(rsp_err),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  int errors = 0;
  int checks = 0;

  // Slave model configuration and observation logs
  int aw_dly = 0, w_dly = 0, b_dly = 0, b_err_idx = -1, r_err_idx = -1;
  logic [31:0] rtbl[$];
  logic [31:0] aw_log[$], w_log[$], ar_log[$];
  logic [31:0] ea[$], ew[$];
  int nb = 0, nr = 0, aw_wait = 0, w_wait = 0, b_wait = 0, aw_cyc = 0, w_cyc = 0;
  bit b_fire = 0, r_fire = 0, slv_clr = 0;

  // Slave acts on the falling edge; a valid&ready pair seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (slv_clr) begin
      aw_log.delete(); w_log.delete(); ar_log.delete();
      nb = 0; nr = 0; aw_wait = 0; w_wait = 0; b_wait = 0; aw_cyc = 0; w_cyc = 0;
      b_fire = 0; r_fire = 0;
      awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
      bresp = 0; rresp = 0; rdata = 0;
      slv_clr = 0;
    end else begin
      if (b_fire) begin
        bvalid = 0; b_fire = 0; nb++;
      end else if (!bvalid && aw_log.size() > nb && w_log.size() > nb) begin
        if (b_wait < b_dly) b_wait++;
        else begin
          bvalid = 1; bresp = (nb == b_err_idx) ? 2'b10 : 2'b00; b_wait = 0;
        end
      end
      if (bvalid && bready) b_fire = 1;

      if (r_fire) begin
        rvalid = 0; r_fire = 0; nr++;
      end else if (!rvalid && ar_log.size() > nr) begin
        rvalid = 1;
        rdata  = (rtbl.size() == 0) ? 32'h0 :
                 (nr < rtbl.size()) ? rtbl[nr] : rtbl[rtbl.size()-1];
        rresp  = (nr == r_err_idx) ? 2'b11 : 2'b00;
      end
      if (rvalid && rready) r_fire = 1;

      if (awvalid) begin
        aw_cyc++;
        if (aw_wait < aw_dly) begin awready = 0; aw_wait++; end
        else begin awready = 1; aw_log.push_back(awaddr); aw_wait = 0; end
      end else begin
        awready = 0; aw_wait = 0;
      end

      if (wvalid) begin
        w_cyc++;
        if (w_wait < w_dly) begin wready = 0; w_wait++; end
        else begin wready = 1; w_log.push_back(wdata); w_wait = 0; end
      end else begin
        wready = 0; w_wait = 0;
      end

      if (arvalid) begin arready = 1; ar_log.push_back(araddr); end
      else arready = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic new_test(input int awd, input int wd, input int bd, input int be, input int re);
    aw_dly = awd; w_dly = wd; b_dly = bd; b_err_idx = be; r_err_idx = re;
    slv_clr = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_cmd(input logic [3:0] a, input logic [3:0] b, input logic clr, input logic rd,
                        input int hold, output logic [3:0] data, output logic err, output int stable);
    int t;
    cmd_a = a; cmd_b = b; cmd_clr = clr; cmd_read = rd; cmd_valid = 1;
    t = 0;
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    check("cmd_ready", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    cmd_valid = 0;
    t = 0;
    while (!rsp_valid && t < 3000) begin @(negedge clk); t++; end
    check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
    data = rsp_data; err = rsp_err; stable = 0;
    repeat (hold) begin
      if (rsp_valid && rsp_data === data && rsp_err === err && !cmd_ready) stable++;
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  task automatic check_writes(input string tag);
    check({tag, "_nwr"}, aw_log.size(), ea.size());
    check({tag, "_nwd"}, w_log.size(), ew.size());
    for (int i = 0; i < ea.size(); i++)
      check($sformatf("%s_awaddr%0d", tag, i), (i < aw_log.size()) ? aw_log[i] : 32'hDEAD_BEEF, ea[i]);
    for (int i = 0; i < ew.size(); i++)
      check($sformatf("%s_wdata%0d", tag, i), (i < w_log.size()) ? w_log[i] : 32'hDEAD_BEEF, ew[i]);
  endtask

  task automatic check_reads(input string tag, input int n);
    check({tag, "_nrd"}, ar_log.size(), n);
    for (int i = 0; i < ar_log.size(); i++)
      check($sformatf("%s_araddr%0d", tag, i), ar_log[i], BASE + 32'h0C);
  endtask

  logic [3:0] d;
  logic       e;
  int         st;

  initial begin
    rst_n = 0; cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_clr = 0; cmd_read = 0; rsp_ready = 0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0; bresp = 0; rresp = 0; rdata = 0;
    repeat (3) @(negedge clk);

    check("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst_valids", {26'b0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 32'd0);
    check("rst_awaddr", awaddr, 32'h0);
    check("rst_wdata", wdata, 32'h0);
    check("rst_araddr", araddr, 32'h0);
    check("rst_rsp", {27'b0, rsp_err, rsp_data}, 32'h0);
    check("rst_wstrb", {28'b0, wstrb}, 32'hF);
    rst_n = 1;
    @(negedge clk);

    // Basic write-only
    new_test(0, 0, 0, -1, -1);
    do_cmd(4'h2, 4'h4, 1'b0, 1'b0, 0, d, e, st);
    ea = '{BASE + 32'h4, BASE + 32'h8, BASE, BASE};
    ew = '{32'h2, 32'h4, 32'h1, 32'h0};
    check_writes("wo");
    check_reads("wo", 0);
    check("wo_rsp", {27'b0, e, d}, 32'h00);

    // Clear and read, valid on the first poll
    rtbl = '{32'h8000_0004};
    new_test(0, 0, 0, -1, -1);
    do_cmd(4'h3, 4'h5, 1'b1, 1'b1, 0, d, e, st);
    ea = '{BASE, BASE, BASE + 32'h4, BASE + 32'h8, BASE, BASE};
    ew = '{32'h2, 32'h0, 32'h3, 32'h5, 32'h1, 32'h0};
    check_writes("clr");
    check_reads("clr", 1);
    check("clr_rsp", {27'b0, e, d}, 32'h04);

    // Polling until valid on the third read
    rtbl = '{32'h0000_0003, 32'h0000_0003, 32'h8000_0005};
    new_test(0, 0, 0, -1, -1);
    do_cmd(4'h1, 4'h1, 1'b0, 1'b1, 0, d, e, st);
    check_reads("poll", 3);
    check("poll_rsp", {27'b0, e, d}, 32'h05);

    // Poll timeout at POLL_MAX=4, data from the last read
    rtbl = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0003, 32'h0000_0006};
    new_test(0, 0, 0, -1, -1);
    do_cmd(4'h1, 4'h1, 1'b0, 1'b1, 0, d, e, st);
    check_reads("tmo", 4);
    check("tmo_rsp", {27'b0, e, d}, 32'h16);

    // AW delayed, W immediate, B stalled
    new_test(3, 0, 5, -1, -1);
    do_cmd(4'h7, 4'h9, 1'b0, 1'b0, 0, d, e, st);
    ea = '{BASE + 32'h4, BASE + 32'h8, BASE, BASE};
    ew = '{32'h7, 32'h9, 32'h1, 32'h0};
    check_writes("awdly");
    check("awdly_aw_cyc", aw_cyc, 16);
    check("awdly_w_cyc", w_cyc, 4);
    check("awdly_rsp", {27'b0, e, d}, 32'h00);

    // W delayed, AW immediate, B stalled
    new_test(0, 3, 5, -1, -1);
    do_cmd(4'hC, 4'h6, 1'b0, 1'b0, 0, d, e, st);
    ea = '{BASE + 32'h4, BASE + 32'h8, BASE, BASE};
    ew = '{32'hC, 32'h6, 32'h1, 32'h0};
    check_writes("wdly");
    check("wdly_aw_cyc", aw_cyc, 4);
    check("wdly_w_cyc", w_cyc, 16);

    // Error response on the operand-B write
    new_test(0, 0, 0, 1, -1);
    do_cmd(4'h3, 4'h4, 1'b0, 1'b1, 0, d, e, st);
    ea = '{BASE + 32'h4, BASE + 32'h8};
    ew = '{32'h3, 32'h4};
    check_writes("berr");
    check_reads("berr", 0);
    check("berr_rsp", {27'b0, e, d}, 32'h10);

    // Error response on the first poll
    rtbl = '{32'h8000_0009};
    new_test(0, 0, 0, -1, 0);
    do_cmd(4'h2, 4'h2, 1'b0, 1'b1, 0, d, e, st);
    check_reads("rerr", 1);
    check("rerr_rsp", {27'b0, e, d}, 32'h19);

    // Response backpressure for 10 cycles
    rtbl = '{32'h8000_000A};
    new_test(0, 0, 0, -1, -1);
    do_cmd(4'h5, 4'h5, 1'b0, 1'b1, 10, d, e, st);
    check("bp_stable", st, 10);
    check("bp_rsp", {27'b0, e, d}, 32'h0A);
    check("bp_cmd_ready", {31'b0, cmd_ready}, 32'd1);

    // Reset while AW is pending
    new_test(5, 5, 0, -1, -1);
    cmd_a = 4'h1; cmd_b = 4'h2; cmd_clr = 0; cmd_read = 0; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0;
    for (int t = 0; t < 20 && !awvalid; t++) @(negedge clk);
    check("rst_mid_aw_up", {31'b0, awvalid}, 32'd1);
    #1 rst_n = 0;
    #1;
    check("rst_mid_valids", {30'b0, awvalid, wvalid}, 32'd0);
    check("rst_mid_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1;
    new_test(0, 0, 0, -1, -1);
    check("rst_rel_cmd_ready", {31'b0, cmd_ready}, 32'd1);
    do_cmd(4'h2, 4'h4, 1'b0, 1'b0, 0, d, e, st);
    ea = '{BASE + 32'h4, BASE + 32'h8, BASE, BASE};
    ew = '{32'h2, 32'h4, 32'h1, 32'h0};
    check_writes("post_rst");
    check("post_rst_rsp", {27'b0, e, d}, 32'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
